// File: rtl/iter_alu.sv
// ---------------------------------------------------------------------------
// iter_alu: multi-cycle execute-stage ALU with NZCV flags.
//
// Simple ops (0-9) finish one cycle after accept. MUL/MULHU use a WIDTH-step
// shift-add; DIV/DIVU/REM/REMU use a WIDTH-step restoring divide on operand
// magnitudes with a sign fix-up on the final step.
//
// Handshake: a request transfers on the rising edge where in_valid and
// in_ready are both high; a result transfers on the rising edge where
// out_valid and out_ready are both high. flush aborts anything in flight.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous abort, priority over both handshakes
//   in_valid/in_ready request handshake (in_ready high only in IDLE)
//   op, a, b          operation code and operands
//   out_valid/out_ready result handshake
//   result, flags     registered result and {N,Z,C,V}
//   o_dbg_state       current FSM state (0 IDLE, 1 BUSY, 2 DONE)
// ---------------------------------------------------------------------------
module iter_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic [1:0]       o_dbg_state
);

    localparam int SHW = $clog2(WIDTH);
    localparam int M   = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state, w_state_nx;
    logic [3:0]       r_op;
    logic             r_a_neg, r_b_neg, r_b_zero;
    logic [WIDTH-1:0] r_hi, r_lo, r_dvs;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;

    logic             w_accept, w_last;
    logic [WIDTH:0]   w_sum, w_dif;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_fast_res;
    logic             w_fast_c, w_fast_v;
    logic             w_div_signed, w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;
    logic             w_is_mul;
    logic [WIDTH:0]   w_mul_sum, w_rem_sh, w_rem_dif;
    logic [WIDTH-1:0] w_hi_nx, w_lo_nx, w_slow_res;

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign result      = r_result;
    assign flags       = r_flags;
    assign o_dbg_state = r_state;

    assign w_accept = (r_state == S_IDLE) && in_valid && !flush;
    assign w_last   = (r_state == S_BUSY) && (r_cnt == SHW'(WIDTH - 1)) && !flush;

    // Single-cycle datapath, evaluated on the live inputs at accept.
    // SUB is a + ~b + 1 so the carry-out is the "no borrow" flag directly.
    always_comb begin
        w_sum      = {1'b0, a} + {1'b0, b};
        w_dif      = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        w_shamt    = b[SHW-1:0];
        w_fast_res = '0;
        w_fast_c   = 1'b0;
        w_fast_v   = 1'b0;
        case (op)
            4'd0: begin
                w_fast_res = w_sum[M:0];
                w_fast_c   = w_sum[WIDTH];
                w_fast_v   = (a[M] == b[M]) && (w_sum[M] != a[M]);
            end
            4'd1: begin
                w_fast_res = w_dif[M:0];
                w_fast_c   = w_dif[WIDTH];
                w_fast_v   = (a[M] != b[M]) && (w_dif[M] != a[M]);
            end
            4'd2:    w_fast_res = a & b;
            4'd3:    w_fast_res = a | b;
            4'd4:    w_fast_res = a ^ b;
            4'd5:    w_fast_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd6:    w_fast_res = {{(WIDTH-1){1'b0}}, (a < b)};
            4'd7:    w_fast_res = a << w_shamt;
            4'd8:    w_fast_res = a >> w_shamt;
            4'd9:    w_fast_res = $unsigned($signed(a) >>> w_shamt);
            default: w_fast_res = '0;
        endcase
    end

    // Operand magnitudes for signed divide (most-negative maps to 2^(W-1)).
    assign w_div_signed = (op == 4'd12) || (op == 4'd14);
    assign w_a_neg      = w_div_signed && a[M];
    assign w_b_neg      = w_div_signed && b[M];
    assign w_a_mag      = w_a_neg ? (~a + 1'b1) : a;
    assign w_b_mag      = w_b_neg ? (~b + 1'b1) : b;

    // One iteration step. Multiply: {r_hi,r_lo} shifts right while the
    // multiplier in r_lo is consumed LSB first. Divide: remainder in r_hi,
    // dividend shifts out of r_lo MSB first while quotient bits shift in.
    // A zero divisor naturally yields quotient all-ones, remainder |a|.
    always_comb begin
        w_is_mul  = (r_op[3:1] == 3'b101);
        w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_dvs} : '0);
        w_rem_sh  = {r_hi, r_lo[M]};
        w_rem_dif = w_rem_sh - {1'b0, r_dvs};
        if (w_is_mul) begin
            w_hi_nx = w_mul_sum[WIDTH:1];
            w_lo_nx = {w_mul_sum[0], r_lo[M:1]};
        end else begin
            w_hi_nx = w_rem_dif[WIDTH] ? w_rem_sh[M:0] : w_rem_dif[M:0];
            w_lo_nx = {r_lo[M-1:0], ~w_rem_dif[WIDTH]};
        end
        case (r_op)
            4'd10:   w_slow_res = w_lo_nx;
            4'd11:   w_slow_res = w_hi_nx;
            4'd12:   w_slow_res = ((r_a_neg ^ r_b_neg) && !r_b_zero) ? (~w_lo_nx + 1'b1) : w_lo_nx;
            4'd13:   w_slow_res = w_lo_nx;
            4'd14:   w_slow_res = r_a_neg ? (~w_hi_nx + 1'b1) : w_hi_nx;
            4'd15:   w_slow_res = w_hi_nx;
            default: w_slow_res = '0;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    // FSM: next state
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nx = (op >= 4'd10) ? S_BUSY : S_DONE;
            S_BUSY:  if (r_cnt == SHW'(WIDTH - 1)) w_state_nx = S_DONE;
            S_DONE:  if (out_ready) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
        if (flush) w_state_nx = S_IDLE;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_a_neg  <= 1'b0;
            r_b_neg  <= 1'b0;
            r_b_zero <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_dvs    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_flags  <= '0;
        end else if (w_accept) begin
            r_op     <= op;
            r_a_neg  <= w_a_neg;
            r_b_neg  <= w_b_neg;
            r_b_zero <= (b == '0);
            r_hi     <= '0;
            r_cnt    <= '0;
            if (op[3:1] == 3'b101) begin
                r_lo  <= b;
                r_dvs <= a;
            end else begin
                r_lo  <= w_a_mag;
                r_dvs <= w_b_mag;
            end
            if (op < 4'd10) begin
                r_result <= w_fast_res;
                r_flags  <= {w_fast_res[M], (w_fast_res == '0), w_fast_c, w_fast_v};
            end
        end else if ((r_state == S_BUSY) && !flush) begin
            r_hi  <= w_hi_nx;
            r_lo  <= w_lo_nx;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_result <= w_slow_res;
                r_flags  <= {w_slow_res[M], (w_slow_res == '0), 2'b00};
            end
        end
    end

endmodule

// File: tb/tb_iter_alu.sv
module tb_iter_alu;
  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    op = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  result;
  logic [3:0]    flags;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [W+3:0] exp_q[$];

  iter_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Returns {flags, result} from plain integer arithmetic.
  function automatic logic [W+3:0] model(input logic [3:0] f_op, input logic [W-1:0] fa, input logic [W-1:0] fb);
    longint sa, sb, ua, ub, t;
    logic [63:0] p;
    logic [W-1:0] r;
    logic c, v;
    sa = longint'($signed(fa));
    sb = longint'($signed(fb));
    ua = longint'({32'b0, fa});
    ub = longint'({32'b0, fb});
    p = {32'b0, fa} * {32'b0, fb};
    c = 1'b0;
    v = 1'b0;
    r = '0;
    case (f_op)
      4'd0: begin t = sa + sb; r = fa + fb; c = (ua + ub) > 64'sd4294967295; v = (t > SMAX) || (t < SMIN); end
      4'd1: begin t = sa - sb; r = fa - fb; c = (ua >= ub); v = (t > SMAX) || (t < SMIN); end
      4'd2: r = fa & fb;
      4'd3: r = fa | fb;
      4'd4: r = fa ^ fb;
      4'd5: r = (sa < sb) ? 1 : 0;
      4'd6: r = (ua < ub) ? 1 : 0;
      4'd7: r = fa << fb[4:0];
      4'd8: r = fa >> fb[4:0];
      4'd9: begin t = sa >>> fb[4:0]; r = t[W-1:0]; end
      4'd10: r = p[31:0];
      4'd11: r = p[63:32];
      4'd12: begin t = (fb == 0) ? -1 : sa / sb; r = t[W-1:0]; end
      4'd13: r = (fb == 0) ? '1 : fa / fb;
      4'd14: begin t = (fb == 0) ? sa : sa % sb; r = t[W-1:0]; end
      default: r = (fb == 0) ? fa : fa % fb;
    endcase
    return {r[W-1], (r == 0), c, v, r};
  endfunction

  // ---------------- driver tasks ----------------
  // Presents one request and returns after the edge that accepts it.
  task automatic send(input logic [3:0] t_op, input logic [W-1:0] ta, input logic [W-1:0] tb);
    int guard = 0;
    while (!in_ready && guard < 200) begin tick(); guard++; end
    if (guard >= 200) chk("in_ready_timeout", 0, 1);
    op = t_op; a = ta; b = tb; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Counts cycles from accept to out_valid (accept cycle = 0).
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin tick(); lat++; end
  endtask

  // Full transaction: drive, check latency, compare against scoreboard head.
  task automatic run_txn(input string name, input logic [3:0] t_op, input logic [W-1:0] ta,
                         input logic [W-1:0] tb, input int stall);
    int lat;
    logic [W+3:0] exp;
    exp_q.push_back(model(t_op, ta, tb));
    send(t_op, ta, tb);
    wait_out(lat);
    chk({name, "_lat"}, 64'(lat), (t_op >= 4'd10) ? 64'(W + 1) : 64'd1);
    repeat (stall) tick();
    exp = exp_q.pop_front();
    chk({name, "_res"}, {28'b0, flags, result}, {28'b0, exp});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, "_idle"}, {62'b0, in_ready, out_valid}, 64'b10);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [3:0]   t_op;
    logic [W-1:0] ta, tb, exp_res;
    logic [3:0]   exp_flg;
    int           lat;
  } vec_t;
  vec_t vecs[14];

  initial begin
    int lat;
    vecs[0]  = '{4'd0,  32'h7FFFFFFF, 32'h1,        32'h80000000, 4'b1001, 1};
    vecs[1]  = '{4'd1,  32'd5,        32'd5,        32'h0,        4'b0110, 1};
    vecs[2]  = '{4'd0,  32'hFFFFFFFF, 32'h1,        32'h0,        4'b0110, 1};
    vecs[3]  = '{4'd10, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFE, 4'b1000, 33};
    vecs[4]  = '{4'd11, 32'hFFFFFFFF, 32'h2,        32'h1,        4'b0000, 33};
    vecs[5]  = '{4'd9,  32'h80000000, 32'h21,       32'hC0000000, 4'b1000, 1};
    vecs[6]  = '{4'd12, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 4'b1000, 33};
    vecs[7]  = '{4'd14, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 4'b1000, 33};
    vecs[8]  = '{4'd13, 32'd7,        32'd0,        32'hFFFFFFFF, 4'b1000, 33};
    vecs[9]  = '{4'd15, 32'd7,        32'd0,        32'd7,        4'b0000, 33};
    vecs[10] = '{4'd12, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b1000, 33};
    vecs[11] = '{4'd14, 32'h80000000, 32'hFFFFFFFF, 32'h0,        4'b0100, 33};
    vecs[12] = '{4'd5,  32'hFFFFFFFF, 32'h1,        32'h1,        4'b0000, 1};
    vecs[13] = '{4'd6,  32'hFFFFFFFF, 32'h1,        32'h0,        4'b0100, 1};

    // reset state
    #12;
    chk("rst_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_result", {28'b0, flags, result}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // directed vectors
    for (int i = 0; i < 14; i++) begin
      send(vecs[i].t_op, vecs[i].ta, vecs[i].tb);
      wait_out(lat);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("vec%0d_res", i), 64'(result), 64'(vecs[i].exp_res));
      chk($sformatf("vec%0d_flg", i), 64'(flags), 64'(vecs[i].exp_flg));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end

    // reset in the middle of a multiply
    send(4'd10, 32'h12345, 32'h777);
    repeat (10) tick();
    chk("mid_mul_busy", {63'b0, in_ready}, 64'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {63'b0, out_valid}, 64'd0);
    chk("arst_ready", {63'b0, in_ready}, 64'd1);
    chk("arst_result", {28'b0, flags, result}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_txn("post_rst_add", 4'd0, 32'd2, 32'd3, 0);

    // backpressure on a divide; a second request must be ignored
    send(4'd13, 32'd100, 32'd7);
    wait_out(lat);
    chk("bp_lat", 64'(lat), 64'(W + 1));
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin op = 4'd0; a = 32'd1; b = 32'd1; in_valid = 1'b1; end
      tick();
      in_valid = 1'b0;
      chk($sformatf("bp_hold%0d", i), {26'b0, out_valid, in_ready, flags, result}, {26'b0, 2'b10, 4'b0000, 32'd14});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release", {28'b0, dbg_state, in_ready, out_valid}, {28'b0, 2'd0, 2'b10});
    chk("bp_no_second", {63'b0, out_valid}, 64'd0);

    // flush during BUSY with a simultaneous request
    send(4'd12, 32'd1000, 32'd3);
    repeat (3) tick();
    flush = 1'b1; in_valid = 1'b1; op = 4'd0; a = 32'd4; b = 32'd4;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle", {62'b0, in_ready, out_valid}, 64'b10);
    lat = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (out_valid) lat++; end
    chk("flush_no_out", 64'(lat), 64'd0);
    chk("flush_holds_result", 64'(result), 64'd14);

    // flush together with a request in IDLE drops the request
    flush = 1'b1; in_valid = 1'b1; op = 4'd0; a = 32'd8; b = 32'd8;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("flush_drop", {62'b0, in_ready, out_valid}, 64'b10);
    run_txn("post_flush_add", 4'd0, 32'd9, 32'd1, 0);

    // randomized traffic against the reference model
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] ra, rb;
      logic [W-1:0] corner[6];
      corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFFFFFF;
      corner[3] = 32'h80000000; corner[4] = 32'h7FFFFFFF; corner[5] = $urandom;
      ra = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 40));
      run_txn($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)), ra, rb, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Parametrised, multi-cycle successor to the single-cycle datapath ALU. Adds shifts, XOR, unsigned compare, and the RV32M multiply/divide group.
- Single-cycle ops return in 1 cycle. MUL/DIV-class ops use a WIDTH-step shift-add / restoring-divide iteration.
- Sits in the execute stage behind a valid/ready handshake, so the pipeline stalls on in_ready/out_valid.
- Produces proper NZCV flags.

Parameters:
- WIDTH, 32, operand/result width; power of two, 8..64.
- SHW, $clog2(WIDTH), shift-amount bits (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort of any in-flight op.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept (high only in IDLE).
- op  in  4  operation code (see Behaviour).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- flags  out  4  {N,Z,C,V}, registered with result.

Behaviour:
- Reset (rst_n low, async): state=IDLE, in_ready=1, out_valid=0, result=0, flags=0, iteration counter=0, internal regs cleared. Takes effect immediately, including mid-operation; the op is lost.
- op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLT (signed), 6 SLTU
  - 7 SLL, 8 SRL, 9 SRA; shift amount = b[SHW-1:0], upper bits ignored
  - 10 MUL (low WIDTH bits), 11 MULHU (high WIDTH bits, unsigned)
  - 12 DIV, 13 DIVU, 14 REM, 15 REMU
- AND/OR/XOR are bitwise. SLT/SLTU return 0 or 1, zero-extended.
- FSM:
  - IDLE: in_ready=1. On in_valid latch op/a/b. Ops 0-9 go to DONE; ops 10-15 go to BUSY with counter=0.
  - BUSY: one iteration per cycle. After WIDTH iterations (counter==WIDTH-1), go to DONE.
  - DONE: out_valid=1. Result and flags stay stable until out_ready=1, then return to IDLE.
- Latency, measured from the accept edge to out_valid high:
  - ops 0-9: 1 cycle.
  - ops 10-15: WIDTH+1 cycles, including divide-by-zero and overflow cases.
- Throughput: one op per 2 cycles at best; no overlap. in_valid while not IDLE is ignored.
- Flags:
  - Z = (result==0) for every op.
  - N = result[WIDTH-1] for every op.
  - ADD: C = unsigned carry-out; V = signed overflow (operands same sign, result sign differs).
  - SUB: C = 1 when no borrow (a>=b unsigned); V = signed overflow (operand signs differ, result sign differs from a).
  - All other ops: C=0, V=0.
- Signed divide: iterate on magnitudes, then fix signs. Quotient is negative iff operand signs differ. Remainder takes the sign of a.
- Divide by zero: DIV/DIVU -> all ones; REM/REMU -> a.
- DIV with a=most-negative, b=-1: result=a. The matching REM result is 0.
- flush: synchronous and has priority over in_valid/out_ready. From any state it goes to IDLE with out_valid=0 next cycle; the result register holds its old value.
- flush and in_valid high in the same cycle in IDLE: the request is dropped.
- out_ready while out_valid=0 has no effect. Results are never dropped without out_ready or flush.

Test Plan:
- Reset mid-MUL (cycle 10 of BUSY), WIDTH=32 -> out_valid=0, in_ready=1, result=0, flags=0 immediately; a new ADD 2+3 after release returns 5 one cycle after accept.
- ADD 0x7FFFFFFF+1 -> result 0x80000000, flags N=1,Z=0,C=0,V=1. SUB 5-5 -> 0, flags Z=1,C=1. ADD 0xFFFFFFFF+1 -> 0, flags Z=1,C=1,V=0.
- MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE and MULHU of the same operands -> 0x00000001, each exactly 33 cycles after accept. SRA 0x80000000 by b=0x21 (amount 1) -> 0xC0000000.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; DIV 0x80000000/-1 -> 0x80000000 with REM 0. All at 33-cycle latency.
- Backpressure: out_ready held low 5 cycles after DIVU 100/7 -> result 14 and flags stay stable, in_ready=0, a second in_valid is ignored. out_ready=1 -> IDLE next cycle.
- flush at BUSY cycle 4 with in_valid=1 the same cycle -> IDLE, out_valid never asserts for either op, and the next accepted ADD returns correctly.
